// File: rtl/output_display_pkg.sv
// Shared definitions for the OUT-register display driver: segment encodings,
// BCD-to-segment decode, conversion engine states and the displayed-result record.
package output_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] BCD_ITER = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_t;

    typedef struct packed {
        logic       neg;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] ones;
    } disp_t;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/output_display_bin2bcd_serial.sv
// Serial 8-bit binary to 3-digit BCD converter (shift-and-add-3), one bit per clock.
//
// state   | meaning
// ST_IDLE | no conversion running, result of last run already handed off
// ST_CONV | iterating; done pulses on the final step with the result on the BCD outputs
module bin2bcd_serial
    import output_display_pkg::*;
(
    input  logic       clk,
    input  logic       clear_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       done
);

    conv_state_t state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] step;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shift register layout: {hundreds, tens, ones, remaining binary bits}
    always_comb begin
        step = sr_q;
        if (step[19:16] >= 4'd5) step[19:16] = step[19:16] + 4'd3;
        if (step[15:12] >= 4'd5) step[15:12] = step[15:12] + 4'd3;
        if (step[11:8]  >= 4'd5) step[11:8]  = step[11:8]  + 4'd3;
        step = {step[18:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CONV;
            ST_CONV: if (!start && cnt_q == 4'd1) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A start on the final step wins, so the interrupted result never escapes.
    always_comb begin
        busy  = (state_q == ST_CONV);
        done  = busy && !start && (cnt_q == 4'd1);
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (start) begin
            sr_d  = {12'd0, bin};
            cnt_d = BCD_ITER;
        end else if (busy) begin
            sr_d  = step;
            cnt_d = cnt_q - 4'd1;
        end
    end

    assign hundreds = step[19:16];
    assign tens     = step[15:12];
    assign ones     = step[11:8];

endmodule

// File: rtl/output_display.sv
// 4-digit multiplexed 7-segment driver for the OUT register: sign/magnitude capture,
// serial decimal conversion, atomic result update and a free-running digit scanner.
module output_display
    import output_display_pkg::*;
#(
    parameter int SCAN_DIV       = 1024,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic       load,
    input  logic [7:0] value,
    input  logic       signed_mode,
    output logic [6:0] seg,
    output logic [3:0] digit_en,
    output logic       busy
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

    logic          neg_in;
    logic [7:0]    mag;
    logic          conv_done;
    logic [3:0]    bcd_h, bcd_t, bcd_o;

    logic          neg_pend_q, neg_pend_d;
    disp_t         disp_q, disp_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    den_q, den_d;

    // 0x80 negates to itself, which is exactly the magnitude 128 we want.
    assign neg_in = signed_mode & value[7];
    assign mag    = neg_in ? (~value + 8'd1) : value;

    bin2bcd_serial u_bin2bcd (
        .clk      (clk),
        .clear_n  (clear_n),
        .start    (load),
        .bin      (mag),
        .busy     (busy),
        .hundreds (bcd_h),
        .tens     (bcd_t),
        .ones     (bcd_o),
        .done     (conv_done)
    );

    function automatic logic [6:0] digit_seg(input logic [1:0] idx, input disp_t d);
        logic [6:0] s;
        case (idx)
            2'd0:    s = bcd_to_seg(d.ones);
            2'd1:    s = (d.hundreds == 4'd0 && d.tens == 4'd0) ? SEG_BLANK : bcd_to_seg(d.tens);
            2'd2:    s = (d.hundreds == 4'd0) ? SEG_BLANK : bcd_to_seg(d.hundreds);
            default: s = d.neg ? SEG_MINUS : SEG_BLANK;
        endcase
        return s;
    endfunction

    always_comb begin
        neg_pend_d = load ? neg_in : neg_pend_q;
        disp_d     = disp_q;
        if (conv_done) begin
            disp_d.neg      = neg_pend_q;
            disp_d.hundreds = bcd_h;
            disp_d.tens     = bcd_t;
            disp_d.ones     = bcd_o;
        end
    end

    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Segment and enable registers load from the same next-state so they never disagree.
    always_comb begin
        seg_d = digit_seg(idx_d, disp_d);
        den_d = 4'b0001 << idx_d;
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            neg_pend_q <= 1'b0;
            disp_q     <= '0;
            pre_q      <= '0;
            idx_q      <= 2'd0;
            seg_q      <= SEG_0;
            den_q      <= 4'b0001;
        end else begin
            neg_pend_q <= neg_pend_d;
            disp_q     <= disp_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            den_q      <= den_d;
        end
    end

    assign seg      = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
    assign digit_en = SEG_ACTIVE_LOW ? ~den_q : den_q;

endmodule

// File: tb/tb_output_display.sv
// Scoreboard bench: stimulus queues expected digit images, a cycle monitor checks both instances.
module tb_output_display;

    localparam int SD_A = 4;
    localparam logic [27:0] ZERO_IMG = {7'h00, 7'h00, 7'h00, 7'h3F};

    logic       clk = 1'b0;
    logic       clear_n = 1'b0;
    logic       load = 1'b0;
    logic [7:0] value = 8'h00;
    logic       signed_mode = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic [3:0] den_a, den_b;
    logic       busy_a, busy_b;

    output_display #(.SCAN_DIV(SD_A), .SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk(clk), .clear_n(clear_n), .load(load), .value(value),
        .signed_mode(signed_mode), .seg(seg_a), .digit_en(den_a), .busy(busy_a)
    );

    output_display #(.SCAN_DIV(1), .SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk(clk), .clear_n(clear_n), .load(load), .value(value),
        .signed_mode(signed_mode), .seg(seg_b), .digit_en(den_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [27:0] exp_q[$];
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Expected image {digit3,digit2,digit1,digit0} from the decimal value of the load.
    function automatic logic [27:0] expect_digits(input logic [7:0] v, input logic sm);
        int n, m;
        logic [6:0] d3, d2, d1, d0;
        n  = sm ? int'($signed(v)) : int'(v);
        m  = (n < 0) ? -n : n;
        d0 = seg_tab[m % 10];
        d1 = (m >= 10)  ? seg_tab[(m / 10) % 10] : 7'h00;
        d2 = (m >= 100) ? seg_tab[m / 100] : 7'h00;
        d3 = (n < 0) ? 7'h40 : 7'h00;
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [3:0] onehot(input int i);
        return 4'(1 << i);
    endfunction

    function automatic logic [6:0] dig(input logic [27:0] img, input int i);
        return img[i*7 +: 7];
    endfunction

    // Reference model of what should be visible: scan positions, busy window, shown image.
    int m_pre_a = 0;
    int m_idx_a = 0;
    int m_idx_b = 0;
    int m_busy  = 0;
    logic [27:0] shown = ZERO_IMG;

    always @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            m_pre_a <= 0;
            m_idx_a <= 0;
            m_idx_b <= 0;
            m_busy  <= 0;
            shown   <= ZERO_IMG;
            exp_q.delete();
        end else begin
            if (m_pre_a == SD_A - 1) begin
                m_pre_a <= 0;
                m_idx_a <= (m_idx_a + 1) % 4;
            end else begin
                m_pre_a <= m_pre_a + 1;
            end
            m_idx_b <= (m_idx_b + 1) % 4;
            if (load) begin
                m_busy <= 8;
            end else if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL scoreboard_underflow @%0t: got 0 entries expected >=1", $time);
                    end else begin
                        shown <= exp_q.pop_front();
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy_a", {31'd0, busy_a}, {31'd0, m_busy != 0});
        check("busy_b", {31'd0, busy_b}, {31'd0, m_busy != 0});
        check("digit_en_a", {28'd0, den_a}, {28'd0, onehot(m_idx_a)});
        check("seg_a", {25'd0, seg_a}, {25'd0, dig(shown, m_idx_a)});
        check("digit_en_b_inv", {28'd0, den_b}, {28'd0, {~onehot(m_idx_b)}});
        check("seg_b_inv", {25'd0, seg_b}, {25'd0, {~dig(shown, m_idx_b)}});
    end

    // Called at a falling edge; the next load is sampled exactly gap rising edges later.
    task automatic do_load(input logic [7:0] v, input logic sm, input int gap);
        load        = 1'b1;
        value       = v;
        signed_mode = sm;
        if (gap > 8) exp_q.push_back(expect_digits(v, sm));
        @(negedge clk);
        load        = 1'b0;
        value       = 8'($urandom);
        signed_mode = 1'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    initial begin
        int g;
        repeat (2) @(negedge clk);
        #2 clear_n = 1'b1;
        @(negedge clk);
        repeat (20) @(negedge clk);

        do_load(8'hFF, 1'b0, 25);
        do_load(8'hFF, 1'b1, 25);
        do_load(8'h80, 1'b1, 25);
        do_load(8'h7F, 1'b1, 25);
        do_load(8'h64, 1'b0, 25);
        do_load(8'h05, 1'b0, 25);
        do_load(8'h2A, 1'b0, 3);
        do_load(8'h07, 1'b0, 25);

        do_load(8'h99, 1'b0, 3);
        #2 clear_n = 1'b0;
        #1;
        check("async_rst_busy", {31'd0, busy_a}, 32'd0);
        check("async_rst_den_a", {28'd0, den_a}, 32'h1);
        check("async_rst_seg_a", {25'd0, seg_a}, 32'h3F);
        check("async_rst_den_b", {28'd0, den_b}, 32'hE);
        check("async_rst_seg_b", {25'd0, seg_b}, 32'h40);
        repeat (2) @(negedge clk);
        #2 clear_n = 1'b1;
        @(negedge clk);
        repeat (20) @(negedge clk);

        do_load(8'hFF, 1'b0, 25);

        for (int i = 0; i < 40; i++) begin
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                            : int'($urandom_range(9, 20));
            do_load(8'($urandom), 1'($urandom), g);
        end
        do_load(8'($urandom), 1'($urandom), 30);
        repeat (20) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
